// File: rtl/reg_read_sb.sv
// Register file read stage with per-register write scoreboard.
// Tracks outstanding writers, stalls ID on pending sources, bypasses same-cycle write-back.
module reg_read_sb #(
  parameter int MAX_PEND = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_addr1,
  input  logic [3:0]  rd_addr2,
  input  logic        rd_use1,
  input  logic        rd_use2,
  output logic [15:0] rd_data1,
  output logic [15:0] rd_data2,
  input  logic        issue,
  input  logic [3:0]  issue_addr,
  input  logic        RegWrite,
  input  logic [3:0]  write_addr,
  input  logic [15:0] RegData,
  input  logic        cancel,
  input  logic [3:0]  cancel_addr,
  output logic        stall,
  output logic        sb_err
);

  logic [15:0] regs    [16];
  logic [1:0]  cnt     [16];
  logic [1:0]  dec     [16];
  logic [1:0]  cnt_nxt [16];
  logic [15:0] pend;
  logic [15:0] under;
  logic        issue_ok;

  // Read ports: R0 is hardwired zero, then same-cycle write-back bypass, then the array.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == 4'd0)
      rd_data1 = '0;
    else if (RegWrite && write_addr == rd_addr1)
      rd_data1 = RegData;

    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == 4'd0)
      rd_data2 = '0;
    else if (RegWrite && write_addr == rd_addr2)
      rd_data2 = RegData;
  end

  // Retire/cancel decrements and the effective pending view; R0 is never tracked.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      dec[r]  = '0;
      pend[r] = 1'b0;
      if (r != 0) begin
        dec[r]  = 2'(RegWrite && write_addr == 4'(r)) + 2'(cancel && cancel_addr == 4'(r));
        pend[r] = (int'(cnt[r]) - int'(dec[r])) > 0;
      end
    end
  end

  assign stall = (rd_use1 && pend[rd_addr1]) ||
                 (rd_use2 && pend[rd_addr2]) ||
                 (issue && int'(cnt[issue_addr]) == MAX_PEND && dec[issue_addr] == 2'd0);

  assign issue_ok = issue && !stall && issue_addr != 4'd0;

  // Next count at full width; a negative result clamps to zero and flags underflow.
  always_comb begin
    int nxt;
    nxt = 0;
    for (int r = 0; r < 16; r++) begin
      cnt_nxt[r] = '0;
      under[r]   = 1'b0;
      if (r != 0) begin
        nxt = int'(cnt[r]) + ((issue_ok && issue_addr == 4'(r)) ? 1 : 0) - int'(dec[r]);
        if (nxt < 0)
          under[r] = 1'b1;
        else
          cnt_nxt[r] = 2'(nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is deliberately reset; architectural state must read 0 after rst.
      for (int r = 0; r < 16; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (RegWrite && write_addr != 4'd0)
        regs[write_addr] <= RegData;
      for (int r = 0; r < 16; r++)
        cnt[r] <= cnt_nxt[r];
      sb_err <= sb_err | (|under);
    end
  end

endmodule

// File: tb/tb_reg_read_sb.sv
// Directed self-checking bench for reg_read_sb: read/write, bypass, stalls,
// saturation, cancel/underflow and reset behaviour.
module tb_reg_read_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        rd_use1, rd_use2;
  logic [15:0] rd_data1, rd_data2;
  logic        issue;
  logic [3:0]  issue_addr;
  logic        RegWrite;
  logic [3:0]  write_addr;
  logic [15:0] RegData;
  logic        cancel;
  logic [3:0]  cancel_addr;
  logic        stall;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_read_sb #(.MAX_PEND(3)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_use1(rd_use1), .rd_use2(rd_use2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .issue(issue), .issue_addr(issue_addr),
    .RegWrite(RegWrite), .write_addr(write_addr), .RegData(RegData),
    .cancel(cancel), .cancel_addr(cancel_addr),
    .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; rd_addr1 = '0; rd_addr2 = '0; rd_use1 = 1'b0; rd_use2 = 1'b0;
    issue = 1'b0; issue_addr = '0; RegWrite = 1'b0; write_addr = '0; RegData = '0;
    cancel = 1'b0; cancel_addr = '0;
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rd_addr1 = 4'd5; rd_addr2 = 4'd15; rd_use1 = 1'b1; rd_use2 = 1'b1;
    #1;
    n_checks++; if (rd_data1 !== 16'h0000) begin $display("FAIL reset_rd1: got %h want 0000", rd_data1); n_fail++; end
    n_checks++; if (rd_data2 !== 16'h0000) begin $display("FAIL reset_rd2: got %h want 0000", rd_data2); n_fail++; end
    n_checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL reset_sb_err: got %b want 0", sb_err); n_fail++; end
    idle();
  endtask

  task automatic test_write_read();
    issue = 1'b1; issue_addr = 4'd5;
    tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd5; RegData = 16'hBEEF;
    tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd0; RegData = 16'hFFFF;
    rd_addr1 = 4'd5; rd_addr2 = 4'd0;
    #1;
    n_checks++; if (rd_data1 !== 16'hBEEF) begin $display("FAIL wr_rd_r5: got %h want beef", rd_data1); n_fail++; end
    n_checks++; if (rd_data2 !== 16'h0000) begin $display("FAIL wr_r0_bypass: got %h want 0000", rd_data2); n_fail++; end
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (rd_data2 !== 16'h0000) begin $display("FAIL wr_r0_stored: got %h want 0000", rd_data2); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL wr_sb_err: got %b want 0", sb_err); n_fail++; end
    idle();
  endtask

  task automatic test_bypass();
    issue = 1'b1; issue_addr = 4'd3;
    tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd3; RegData = 16'h0001;
    issue = 1'b1; issue_addr = 4'd3;
    tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd3; RegData = 16'h1234;
    rd_addr1 = 4'd3; rd_use1 = 1'b1;
    #1;
    n_checks++; if (rd_data1 !== 16'h1234) begin $display("FAIL bypass_data: got %h want 1234", rd_data1); n_fail++; end
    n_checks++; if (stall !== 1'b0) begin $display("FAIL bypass_stall: got %b want 0", stall); n_fail++; end
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (rd_data1 !== 16'h1234) begin $display("FAIL bypass_stored: got %h want 1234", rd_data1); n_fail++; end
    idle();
  endtask

  task automatic test_load_use();
    issue = 1'b1; issue_addr = 4'd7;
    tick();
    idle();
    rd_addr1 = 4'd7; rd_use1 = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin $display("FAIL lu_stall_c1: got %b want 1", stall); n_fail++; end
    tick();
    n_checks++; if (stall !== 1'b1) begin $display("FAIL lu_stall_c2: got %b want 1", stall); n_fail++; end
    rd_use1 = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL lu_unused_src: got %b want 0", stall); n_fail++; end
    // A stalled issue to R8 must not be recorded.
    rd_use1 = 1'b1; issue = 1'b1; issue_addr = 4'd8;
    tick();
    issue = 1'b0;
    RegWrite = 1'b1; write_addr = 4'd7; RegData = 16'h5A5A;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL lu_retire_stall: got %b want 0", stall); n_fail++; end
    n_checks++; if (rd_data1 !== 16'h5A5A) begin $display("FAIL lu_retire_data: got %h want 5a5a", rd_data1); n_fail++; end
    tick();
    idle();
    rd_addr1 = 4'd8; rd_use1 = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL lu_stalled_issue: got %b want 0", stall); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL lu_sb_err: got %b want 0", sb_err); n_fail++; end
    idle();
  endtask

  task automatic test_saturation();
    issue = 1'b1; issue_addr = 4'd2;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (stall !== 1'b1) begin $display("FAIL sat_4th_issue: got %b want 1", stall); n_fail++; end
    tick();
    n_checks++; if (stall !== 1'b1) begin $display("FAIL sat_held_at_max: got %b want 1", stall); n_fail++; end
    RegWrite = 1'b1; write_addr = 4'd2; RegData = 16'h2222;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL sat_issue_retire: got %b want 0", stall); n_fail++; end
    tick();
    idle();
    rd_addr1 = 4'd2; rd_use1 = 1'b1;
    RegWrite = 1'b1; write_addr = 4'd2; RegData = 16'h2222;
    tick();
    tick();
    n_checks++; if (stall !== 1'b0) begin $display("FAIL sat_last_retire: got %b want 0", stall); n_fail++; end
    RegWrite = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) begin $display("FAIL sat_one_left: got %b want 1", stall); n_fail++; end
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL sat_drained: got %b want 0", stall); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL sat_no_err: got %b want 0", sb_err); n_fail++; end
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (sb_err !== 1'b1) begin $display("FAIL sat_extra_retire_err: got %b want 1", sb_err); n_fail++; end
    do_reset();
  endtask

  task automatic test_cancel();
    issue = 1'b1; issue_addr = 4'd4;
    tick();
    tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd4; RegData = 16'h4444;
    cancel = 1'b1; cancel_addr = 4'd4;
    rd_addr1 = 4'd4; rd_use1 = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL cx_same_cycle_stall: got %b want 0", stall); n_fail++; end
    tick();
    RegWrite = 1'b0; cancel = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin $display("FAIL cx_cleared_stall: got %b want 0", stall); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL cx_no_err: got %b want 0", sb_err); n_fail++; end
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (sb_err !== 1'b1) begin $display("FAIL cx_underflow_err: got %b want 1", sb_err); n_fail++; end
    n_checks++; if (stall !== 1'b0) begin $display("FAIL cx_clamped_zero: got %b want 0", stall); n_fail++; end
    issue = 1'b1; issue_addr = 4'd4;
    tick();
    issue = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) begin $display("FAIL cx_count_after_clamp: got %b want 1", stall); n_fail++; end
    n_checks++; if (sb_err !== 1'b1) begin $display("FAIL cx_err_sticky: got %b want 1", sb_err); n_fail++; end
    idle();
  endtask

  task automatic test_reset_mid();
    issue = 1'b1; issue_addr = 4'd9;  tick();
    issue_addr = 4'd10; tick();
    issue_addr = 4'd6;  tick();
    idle();
    RegWrite = 1'b1; write_addr = 4'd6; RegData = 16'h7777;
    tick();
    idle();
    rst = 1'b1;
    issue = 1'b1; issue_addr = 4'd11;
    RegWrite = 1'b1; write_addr = 4'd12; RegData = 16'h1111;
    cancel = 1'b1; cancel_addr = 4'd4;
    tick();
    idle();
    rd_addr1 = 4'd6; rd_addr2 = 4'd12;
    #1;
    n_checks++; if (rd_data1 !== 16'h0000) begin $display("FAIL rm_r6_cleared: got %h want 0000", rd_data1); n_fail++; end
    n_checks++; if (rd_data2 !== 16'h0000) begin $display("FAIL rm_r12_blocked: got %h want 0000", rd_data2); n_fail++; end
    n_checks++; if (sb_err !== 1'b0) begin $display("FAIL rm_sb_err: got %b want 0", sb_err); n_fail++; end
    rd_addr1 = 4'd9; rd_addr2 = 4'd10;
    for (int p = 0; p < 4; p++) begin
      rd_use1 = p[0]; rd_use2 = p[1];
      #1;
      n_checks++; if (stall !== 1'b0) begin $display("FAIL rm_stall_9_10_use%0d: got %b want 0", p, stall); n_fail++; end
    end
    rd_addr1 = 4'd11; rd_addr2 = 4'd4;
    for (int p = 0; p < 4; p++) begin
      rd_use1 = p[0]; rd_use2 = p[1];
      #1;
      n_checks++; if (stall !== 1'b0) begin $display("FAIL rm_stall_11_4_use%0d: got %b want 0", p, stall); n_fail++; end
    end
    idle();
    RegWrite = 1'b1; write_addr = 4'd9; RegData = 16'h9999;
    tick();
    idle();
    #1;
    n_checks++; if (sb_err !== 1'b1) begin $display("FAIL rm_post_reset_err: got %b want 1", sb_err); n_fail++; end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_saturation();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
